// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit that owns the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MDU_EARLY_TERM_EN to let a multiply finish as soon as the remaining multiplier bits are zero.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               dz, dz_nx;
  logic               done_nx, div_zero_nx;

  logic [2*WIDTH-1:0] acc, acc_mul_nx, acc_div_nx, mul_step, prod_fix;
  logic [WIDTH-1:0]   op_m, mplr, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic               neg_q, neg_r, is_div;
  logic               accept, op_mul, op_div, signed_op, mul_early;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    mag = (sgn && v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v, input logic n);
    neg_w = n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] v, input logic n);
    neg_2w = n ? -v : v;
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign op_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign op_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign busy      = (state != S_IDLE);

  // One shift-add multiply step and one restoring-divide step; acc holds {hi_part, lo_part}.
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, op_m} : '0);
    mul_step   = {mul_sum, acc[WIDTH-1:1]};
    acc_mul_nx = mul_step;
    mul_early  = 1'b0;
`ifdef MDU_EARLY_TERM_EN
    if (mplr[WIDTH-1:1] == '0 && cnt > CNT_W'(1)) begin
      mul_early  = 1'b1;
      acc_mul_nx = mul_step >> (cnt - CNT_W'(1));
    end
`endif
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh - {1'b0, op_m};
    if (!div_diff[WIDTH])
      acc_div_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_div_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_2w(acc, neg_q);
    quo_fix  = neg_w(acc[WIDTH-1:0], neg_q);
    rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    dz_nx       = dz;
    done_nx     = 1'b0;
    div_zero_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && op_mul) begin
          state_nx = S_MUL;
          cnt_nx   = CNT_W'(WIDTH);
          dz_nx    = 1'b0;
        end else if (start && op_div) begin
          dz_nx = (srcb == '0);
          if (srcb == '0) begin
            state_nx = S_FIX;
            cnt_nx   = '0;
          end else begin
            state_nx = S_DIV;
            cnt_nx   = CNT_W'(WIDTH);
          end
        end
      end
      S_MUL: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1) || mul_early) begin
          state_nx = S_FIX;
          cnt_nx   = '0;
        end
      end
      S_DIV: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = S_FIX;
      end
      S_FIX: begin
        state_nx    = S_IDLE;
        done_nx     = 1'b1;
        div_zero_nx = dz;
        dz_nx       = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dz       <= dz_nx;
      done     <= done_nx;
      div_zero <= div_zero_nx;
    end
  end

  // Working operands only matter between acceptance and FIX, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && op_mul) begin
      op_m   <= mag(srca, signed_op);
      mplr   <= mag(srcb, signed_op);
      acc    <= '0;
      neg_q  <= signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else if (accept && op_div) begin
      op_m   <= mag(srcb, signed_op);
      mplr   <= '0;
      acc    <= {{WIDTH{1'b0}}, mag(srca, signed_op)};
      neg_q  <= signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_r  <= signed_op && srca[WIDTH-1];
      is_div <= 1'b1;
    end else if (state == S_MUL) begin
      acc  <= acc_mul_nx;
      mplr <= mplr >> 1;
    end else if (state == S_DIV) begin
      acc <= acc_div_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && md_op == OP_MTHI) begin
      hi <= srca;
    end else if (accept && md_op == OP_MTLO) begin
      lo <= srca;
    end else if (state == S_FIX && !dz) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        {hi, lo} <= prod_fix;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed table-driven bench for mdu_seq, plus hand sequences for divide-by-zero, busy-time starts and reset abort.
`timescale 1ns/1ps
module tb_mdu_seq;

  localparam int W = 32;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;
  localparam int NV = 12;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   md_op;
  logic [W-1:0] srca, srcb, hi, lo;
  logic         busy, done, div_zero;

  int n_vec = 0;
  int n_err = 0;

  mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .srca(srca), .srcb(srcb), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          lat_et;
  } vec_t;

  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int lat, output logic got,
                        output logic dzs, output logic bsy);
    start = 1'b1; md_op = op; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE; srca = ~a; srcb = ~b;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    lat = 0; got = 1'b0; dzs = 1'b0; bsy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1; dzs = div_zero; bsy = busy;
        break;
      end
      if (busy) lat++;
      if (inj >= 0 && lat == inj) begin
        start = 1'b1; md_op = OP_MULT; srca = 32'hDEAD_BEEF; srcb = 32'd2;
      end else begin
        start = 1'b0; md_op = OP_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; md_op = OP_NONE;
    chk("timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] v);
    start = 1'b1; md_op = op; srca = v;
    @(posedge clk); #1;
    chk("mt_busy", {31'b0, busy}, 32'd0);
    chk(op == OP_MTHI ? "mthi_val" : "mtlo_val", op == OP_MTHI ? hi : lo, v);
    start = 1'b0; md_op = OP_NONE; srca = ~v;
    @(negedge clk);
    chk("mt_done", {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, exp_lat, dcnt;
    logic got, dzs, bsy;

    reset = 1'b0; start = 1'b0; md_op = OP_NONE; srca = '0; srcb = '0;

    vt[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 33};
    vt[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 4};
    vt[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33};
    vt[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 33};
    vt[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 33};
    vt[5]  = '{OP_MULTU, 32'd5,         32'd1,         32'd0,         32'd5,         33, 2};
    vt[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 33};
    vt[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 33};
    vt[8]  = '{OP_MULT,  32'd6,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 33, 4};
    vt[9]  = '{OP_MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         33, 2};
    vt[10] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 18};
    vt[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, 33};

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ctl", {29'b0, busy, done, div_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    start = 1'b1; md_op = OP_RSV; srca = 32'h1111_1111; srcb = 32'd3;
    @(negedge clk);
    chk("rsv_busy", {31'b0, busy}, 32'd0);
    md_op = OP_NONE;
    @(negedge clk);
    chk("none_busy", {31'b0, busy}, 32'd0);
    chk("ignored_hilo", hi | lo, 32'd0);
    start = 1'b0;

    do_mt(OP_MTHI, 32'hCAFE_BABE);
    chk("mthi_lo_kept", lo, 32'd0);

    for (int i = 0; i < NV; i++) begin
`ifdef MDU_EARLY_TERM_EN
      exp_lat = vt[i].lat_et;
`else
      exp_lat = vt[i].lat;
`endif
      run_op(vt[i].op, vt[i].a, vt[i].b, -1, lat, got, dzs, bsy);
      chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("v%0d_dz", i), {31'b0, dzs}, 32'd0);
      chk($sformatf("v%0d_lat", i), lat, exp_lat);
      chk($sformatf("v%0d_idle_at_done", i), {31'b0, bsy}, 32'd0);
    end

    do_mt(OP_MTHI, 32'h11);
    do_mt(OP_MTLO, 32'h22);
    run_op(OP_DIV, 32'h1234, 32'd0, -1, lat, got, dzs, bsy);
    chk("dz_flag", {31'b0, dzs}, 32'd1);
    chk("dz_lat", lat, 32'd1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    @(negedge clk);
    chk("dz_pulse_end", {30'b0, done, div_zero}, 32'd0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, got, dzs, bsy);
    chk("inj_hi", hi, 32'hFFFF_FFFE);
    chk("inj_lo", lo, 32'h0000_0001);
    chk("inj_lat", lat, 32'd33);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("inj_no_extra_done", dcnt, 32'd0);

    start = 1'b1; md_op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    repeat (10) @(negedge clk);
    chk("abort_pre_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_ctl", {29'b0, busy, done, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_quiet", dcnt, 32'd0);
    chk("abort_lo_kept", lo, 32'd0);

    @(negedge clk);
`ifdef MDU_EARLY_TERM_EN
    exp_lat = 2;
`else
    exp_lat = 33;
`endif
    run_op(OP_MULTU, 32'd5, 32'd1, -1, lat, got, dzs, bsy);
    chk("post_rst_lo", lo, 32'd5);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lat", lat, exp_lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle integer multiply/divide unit in the execute stage, fed directly by the main decoder.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Raises busy so hazard logic stalls the pipeline until the result has been written.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, issue strobe from decode/execute; sampled on the rising edge.
- md_op, input, 3, operation code:
  - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 111 is reserved.
- srca, input, WIDTH, rs operand: multiplicand, dividend, or MTHI/MTLO source.
- srcb, input, WIDTH, rt operand: multiplier or divisor.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.
- busy, output, 1, high while an operation is in flight; drives the pipeline stall.
- done, output, 1, one-cycle pulse when HI/LO receive a MULT/DIV result.
- div_zero, output, 1, one-cycle pulse, coincident with done, for a divide by zero.

Behaviour:
- Reset:
  - reset low forces hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE and counter 0.
  - Reset takes effect immediately and is asynchronous to clk.
  - Reset mid-operation aborts the operation; no result is written.
- States are IDLE, MUL, DIV and FIX. busy = (state != IDLE). done and div_zero are registered.
- Acceptance:
  - start is honoured only in IDLE.
  - start while busy is ignored; upstream must hold its instruction under stall.
  - start with md_op 000 or 111 is ignored.
- MTHI/MTLO: on the accepting edge hi (or lo) <= srca. State stays IDLE, busy stays 0, done is not pulsed.
- MULT/MULTU, accepted on edge N:
  - Latch the operands. For MULT, latch magnitudes and record sign = srca[31]^srcb[31]. Set counter = WIDTH; go to MUL.
  - MUL, one step per edge: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator; then shift the accumulator and multiplier right by 1; decrement the counter.
  - When the counter reaches 0, go to FIX.
  - FIX applies two's-complement negation to the 64-bit product if sign is set (MULT only).
  - The FIX edge, N+WIDTH+1, writes {hi,lo} <= product and returns to IDLE.
  - done is high during cycle N+WIDTH+1 to N+WIDTH+2 (one cycle). busy is high for WIDTH+1 cycles.
- DIV/DIVU:
  - Use restoring division on magnitudes: shift the remainder left, bring in the dividend MSB, then trial-subtract the divisor. If non-negative, keep the difference and set the quotient bit to 1, else set it to 0.
  - Timing is identical to multiply: WIDTH iterations in DIV, then FIX.
  - FIX for DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - lo <= quotient, hi <= remainder.
  - -2^31 / -1 (DIV) yields lo=0x80000000, hi=0 from natural truncation; no flag is raised.
- Divide by zero (srcb==0 on acceptance):
  - No iteration is performed; the unit goes to FIX for one cycle.
  - hi/lo are left unchanged; done and div_zero pulse together.
- Operand capture:
  - srca and srcb are sampled only on the accepting edge.
  - Later changes on srca and srcb have no effect.
- Back-to-back: a new start is accepted in the same cycle that done is high, since the state is already IDLE.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - In MUL, if the remaining multiplier bits are all zero, jump to FIX and align the accumulator by the remaining shift count.
  - Minimum MULT latency is therefore 2 cycles (multiplier 0 or 1).
  - Results are bit-identical to the non-early-termination result.
  - DIV timing is unaffected.
- Undefined: the fixed WIDTH+1 cycle multiply latency described above.

Test Plan:
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle; busy high for exactly 33 cycles.
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 100/7 -> lo=14, hi=2.
- DIV with srcb=0 and prior hi=0x11, lo=0x22 -> div_zero and done pulse together after 1 cycle; hi/lo unchanged.
- MTHI srca=0xCAFEBABE -> hi updated on the same edge, busy never rises. start asserted mid-MULT -> ignored and the result is unaffected. reset pulsed low mid-DIV -> hi=lo=0 and busy=0 immediately.
- With MDU_EARLY_TERM_EN defined: MULTU 5*1 -> lo=5, hi=0, done within 2 cycles. Without the macro, the same operation takes 33 cycles.
